// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. It converts the serial rx line into parallel
//                words, LSB first, 8N1 by default. Bit timing is counted in
//                sample_tick strobes, which run at SAMPLE x baud. The start bit
//                is qualified at its midpoint. Each later bit is then sampled
//                one full bit period after the previous decision, so it is
//                also sampled at its midpoint.
//  Optional    : `define UART_RX_PARITY_EN adds one parity bit between the data
//                and the stop bit. It also adds the PARITY_ODD parameter and
//                the parity_err output.
//  Ports       : SysClk      - system clock, rising edge
//                rst         - asynchronous active-high reset
//                sample_tick - one-cycle strobe at SAMPLE x baud
//                rx          - asynchronous serial input, idle high
//                rx_data     - last correctly framed word, held until the next
//                              good frame
//                rx_valid    - one-cycle pulse when rx_data updates
//                framing_err - one-cycle pulse when the stop bit is sampled low
//                busy        - high whenever the receiver is not idle
//                parity_err  - (parity build only) one-cycle pulse on a parity
//                              mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,
`ifdef UART_RX_PARITY_EN
    parameter bit PARITY_ODD = 1'b0,
`endif
    parameter int SAMPLE     = 16
) (
    input  logic                 SysClk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int c_CNT_W = $clog2(SAMPLE);
    localparam int c_IDX_W = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(SAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_END  = c_CNT_W'(SAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
    localparam logic [2:0] c_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd5;
`endif

    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_framing_err;
    logic                 w_mid;
    logic                 w_end;
    logic                 w_good;
    logic                 w_bad_stop;
    logic                 w_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit;
    logic                 r_parity_err;
    logic                 w_par_ok;
    logic                 w_par_fail;
`endif

    // Sample points within the current state. Every decision needs a tick.
    assign w_mid = sample_tick && (r_cnt == c_CNT_MID);
    assign w_end = sample_tick && (r_cnt == c_CNT_END);

    // Two-flop synchronizer. It resets to the idle level, so that reset
    // release does not look like a start bit.
    always_ff @(posedge SysClk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // State register
    always_ff @(posedge SysClk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (sample_tick && !r_rxs) begin
                    w_next = c_START;
                end
            end
            c_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (w_mid) begin
                    w_next = r_rxs ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_end && (r_idx == c_IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = c_PARITY;
`else
                    w_next = c_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_PARITY: begin
                if (w_end) begin
                    w_next = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_end) begin
                    w_next = r_rxs ? c_IDLE : c_BREAK;
                end
            end
            c_BREAK: begin
                // Stay here until the line goes high, so that a held-low
                // line does not start a new frame.
                if (sample_tick && r_rxs) begin
                    w_next = c_IDLE;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // Output / decision logic
    always_comb begin
        w_busy     = (r_state != c_IDLE);
        w_good     = 1'b0;
        w_bad_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_ok   = (((^r_shift) ^ r_par_bit) == PARITY_ODD);
        w_par_fail = 1'b0;
`endif
        if ((r_state == c_STOP) && w_end) begin
            if (r_rxs) begin
`ifdef UART_RX_PARITY_EN
                w_good     = w_par_ok;
                w_par_fail = !w_par_ok;
`else
                w_good     = 1'b1;
`endif
            end else begin
                w_bad_stop = 1'b1;
            end
        end
    end

    // Datapath: tick counter, bit index, shift register, result registers
    always_ff @(posedge SysClk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit     <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            // Clearing the counter on every state change keeps each state's
            // sample points relative to the moment the state was entered.
            if (r_state != w_next) begin
                r_cnt <= '0;
            end else if (sample_tick) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if ((r_state == c_START) && w_mid && !r_rxs) begin
                r_idx <= '0;
            end

            if ((r_state == c_DATA) && w_end) begin
                // LSB first: the first bit received ends up in bit 0.
                r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                r_idx   <= r_idx + c_IDX_W'(1);
            end

`ifdef UART_RX_PARITY_EN
            if ((r_state == c_PARITY) && w_end) begin
                r_par_bit <= r_rxs;
            end
            r_parity_err  <= w_par_fail;
`endif

            if (w_good) begin
                r_rx_data <= r_shift;
            end
            r_rx_valid    <= w_good;
            r_framing_err <= w_bad_stop;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign framing_err = r_framing_err;
    assign busy        = w_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`endif

endmodule
`default_nettype wire
